// File: rtl/vga_if.sv
// VGA timing and colour bundle handed from one overlay stage to the next.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/animation_ladder_multi.sv
// Overlays N_LADDERS animated ladder sprites on the VGA stream; the ladders grow,
// hold and shrink one segment per FRAMES_PER_STEP frames under a local FSM.
module animation_ladder_multi #(
  parameter int          N_LADDERS       = 2,
  parameter int          X0              = 480,
  parameter int          X_PITCH         = 36,
  parameter int          SPRITE_W        = 32,
  parameter int          SPRITE_H        = 32,
  parameter int          Y_TOP           = 271,
  parameter int          Y_BOTTOM        = 768,
  parameter int          MAX_SEG         = 15,
  parameter int          FRAMES_PER_STEP = 4,
  parameter logic [11:0] KEY_RGB         = 12'h000
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_game,
  input  logic                                        grow_req,
  input  logic                                        shrink_req,
  input  logic [11:0]                                 rgb_pixel,
  output logic [$clog2(SPRITE_H)+$clog2(SPRITE_W)-1:0] pixel_addr,
  output logic [3:0]                                  seg_count,
  output logic                                        busy,
  output logic                                        done,
  vga_if.in                                           in,
  vga_if.out                                          out
);

  localparam int ROW_W = $clog2(SPRITE_H);
  localparam int COL_W = $clog2(SPRITE_W);
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [11:0]      Y_TOP_U  = 12'(Y_TOP);
  localparam logic [11:0]      Y_BOT_U  = 12'(Y_BOTTOM);
  localparam logic [3:0]       SEG_MAX  = 4'(MAX_SEG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef enum logic [1:0] {IDLE, GROW, HOLD, SHRINK} state_t;

  function automatic logic [11:0] ladder_x(input int i);
    return 12'(X0 + i * X_PITCH);
  endfunction

  function automatic logic in_ladder(input logic [11:0] h, input int i);
    return (h >= ladder_x(i)) && (h < ladder_x(i) + 12'(SPRITE_W));
  endfunction

  function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
    return (b > a) ? 12'd0 : a - b;
  endfunction

  function automatic logic [11:0] umax(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? a : b;
  endfunction

  vga_t vga_p0, vga_p1, vga_p2, vga_p3, vga_o;
  logic [ROW_W+COL_W-1:0] addr_nxt;
  logic [11:0] y_start;
  logic v_hit, h_hit, hit_p2;

  assign vga_p0 = {in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk, in.rgb};

  // Stage 1: ROM address from the incoming pixel; held when no ladder column matches
  always_comb begin
    addr_nxt = pixel_addr;
    for (int i = 0; i < N_LADDERS; i++) begin
      if (in_ladder({1'b0, vga_p0.hcount}, i))
        addr_nxt = {vga_p0.vcount[ROW_W-1:0], COL_W'({1'b0, vga_p0.hcount} - ladder_x(i))};
    end
  end

  // Stage 2: hit test on delayed counters while the ROM texel arrives
  always_comb begin
    y_start = umax(Y_TOP_U, sat_sub(Y_BOT_U, 12'(SPRITE_H) * {8'd0, seg_count}));
    v_hit   = (seg_count != 4'd0) && ({1'b0, vga_p2.vcount} >= y_start) &&
              ({1'b0, vga_p2.vcount} < Y_BOT_U);
    h_hit   = 1'b0;
    for (int i = 0; i < N_LADDERS; i++) begin
      if (in_ladder({1'b0, vga_p2.hcount}, i)) h_hit = 1'b1;
    end
    hit_p2 = v_hit && h_hit;
  end

  // Stage 3: colour select into the output register
  always_comb begin
    vga_o = vga_p2;
    if (vga_p2.vblnk || vga_p2.hblnk)       vga_o.rgb = 12'h888;
    else if (hit_p2 && rgb_pixel != KEY_RGB) vga_o.rgb = rgb_pixel;
    else                                      vga_o.rgb = vga_p2.rgb;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_p1     <= '0;
      vga_p2     <= '0;
      vga_p3     <= '0;
      pixel_addr <= '0;
    end else begin
      vga_p1     <= vga_p0;
      pixel_addr <= addr_nxt;
      vga_p2     <= vga_p1;
      vga_p3     <= vga_o;
    end
  end

  assign out.vcount = vga_p3.vcount;
  assign out.vsync  = vga_p3.vsync;
  assign out.vblnk  = vga_p3.vblnk;
  assign out.hcount = vga_p3.hcount;
  assign out.hsync  = vga_p3.hsync;
  assign out.hblnk  = vga_p3.hblnk;
  assign out.rgb    = vga_p3.rgb;

  state_t           state, state_nxt;
  logic [3:0]       seg_nxt;
  logic [CNT_W-1:0] frame_cnt, cnt_nxt;
  logic             done_nxt, tick, step;

  // Steps land only on the frame-start pixel, so seg_count never changes mid-frame
  assign tick = (in.vcount == 11'd0) && (in.hcount == 11'd0);
  assign step = tick && (frame_cnt == CNT_LAST);
  assign busy = (state == GROW) || (state == SHRINK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      seg_count <= 4'd0;
      frame_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      seg_count <= seg_nxt;
      frame_cnt <= cnt_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    seg_nxt   = seg_count;
    cnt_nxt   = frame_cnt;
    done_nxt  = 1'b0;
    if (tick) cnt_nxt = (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
    if (!start_game) begin
      state_nxt = IDLE;
      seg_nxt   = 4'd0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (grow_req && seg_count < SEG_MAX) begin
          state_nxt = GROW;
          cnt_nxt   = '0;
        end
        GROW: if (step) begin
          seg_nxt = seg_count + 4'd1;
          if (seg_count == SEG_MAX - 4'd1) begin
            state_nxt = HOLD;
            done_nxt  = 1'b1;
          end
        end
        HOLD: if (shrink_req) begin
          state_nxt = SHRINK;
          cnt_nxt   = '0;
        end
        SHRINK: if (step) begin
          seg_nxt = seg_count - 4'd1;
          if (seg_count == 4'd1) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
